pc_gen: RTL and testbench

Parametrised program-counter generator for the RV32IM fetch stage. It holds the architectural fetch PC and presents it to instruction memory through a valid/ready handshake. It selects the next PC from trap, redirect, return-address-stack prediction or sequential increment, and flags misaligned control-flow targets. It sits between the execute/trap logic and the instruction memory port.

---
 rtl/pc_gen_if.sv | 9 +
 rtl/pc_gen.sv | 82 ++++++++
 tb/tb_pc_gen.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch request bus between the PC generator and instruction memory
interface pc_gen_if #(parameter int XLEN = 32);
  logic fetch_valid;
  logic fetch_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus;
  modport master(output fetch_valid, pc, pc_plus, input fetch_ready);
  modport slave(input fetch_valid, pc, pc_plus, output fetch_ready);
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with trap/redirect/RAS/sequential next-PC selection
module pc_gen #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int INCR = 1,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  pc_gen_if.master        f,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic            ras_empty,
  output logic            misaligned_fault
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
  state_t state;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0] top, top_inc, top_dec;
  logic [CW-1:0] cnt;
  logic accept, pop_hit, mis;
  assign f.pc = pc_r;
  assign f.pc_plus = pc_r + XLEN'(INCR);
  assign f.fetch_valid = state == RUN;
  assign misaligned_fault = state == FAULT;
  assign ras_empty = cnt == '0;
  assign accept = state == RUN && f.fetch_ready && !stall;
  assign pop_hit = ras_pop && !ras_empty;
  assign mis = INCR == 4 && redirect_target[1:0] != 2'b00;
  // circular stack: top always indexes the newest entry, oldest is overwritten when full
  assign top_inc = top == PW'(RAS_DEPTH - 1) ? '0 : top + 1'b1;
  assign top_dec = top == '0 ? PW'(RAS_DEPTH - 1) : top - 1'b1;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= BOOT;
      pc_r <= RESET_VECTOR;
      cnt <= '0;
      top <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (trap_valid) begin
            pc_r <= trap_target;
            cnt <= '0;
          end else if (redirect_valid) begin
            pc_r <= redirect_target;
            if (mis) state <= FAULT;
          end else if (accept) begin
            pc_r <= pop_hit ? ras[top] : f.pc_plus;
            if (ras_push && pop_hit) begin
              ras[top] <= f.pc_plus;
            end else if (ras_push) begin
              ras[top_inc] <= f.pc_plus;
              top <= top_inc;
              cnt <= cnt == CW'(RAS_DEPTH) ? cnt : cnt + 1'b1;
            end else if (pop_hit) begin
              top <= top_dec;
              cnt <= cnt - 1'b1;
            end
          end
        end
        FAULT: begin
          if (trap_valid) begin
            state <= RUN;
            pc_r <= trap_target;
            cnt <= '0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vectors plus randomized run of two pc_gen configurations against a reference model
module tb_pc_gen;
  logic clk = 0, rst = 0, ready = 0, stall = 0, rv = 0, tv = 0, push = 0, pop = 0;
  logic [31:0] rt = 0, tt = 0;
  logic re4, mf4, re1, mf1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pc_gen_if #(.XLEN(32)) f4();
  pc_gen_if #(.XLEN(32)) f1();
  assign f4.fetch_ready = ready;
  assign f1.fetch_ready = ready;
  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h100), .INCR(4), .RAS_DEPTH(4)) d4 (
    .clk(clk), .rst(rst), .f(f4), .stall(stall), .redirect_valid(rv), .redirect_target(rt),
    .trap_valid(tv), .trap_target(tt), .ras_push(push), .ras_pop(pop),
    .ras_empty(re4), .misaligned_fault(mf4));
  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .INCR(1), .RAS_DEPTH(4)) d1 (
    .clk(clk), .rst(rst), .f(f1), .stall(stall), .redirect_valid(rv), .redirect_target(rt),
    .trap_valid(tv), .trap_target(tt), .ras_push(push), .ras_pop(pop),
    .ras_empty(re1), .misaligned_fault(mf1));
  // reference model, index 0 = byte-addressed config, 1 = word-addressed config
  bit minit = 0;
  int mst [2];
  logic [31:0] mpc [2];
  logic [31:0] mras [2][4];
  int msz [2];
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] pp;
      pp = mpc[k] + (k == 0 ? 32'd4 : 32'd1);
      if (!rst) begin
        mst[k] = 0;
        mpc[k] = k == 0 ? 32'h100 : 32'h0;
        msz[k] = 0;
      end else if (mst[k] == 0) begin
        mst[k] = 1;
      end else if (mst[k] == 2) begin
        if (tv) begin mst[k] = 1; mpc[k] = tt; msz[k] = 0; end
      end else if (tv) begin
        mpc[k] = tt;
        msz[k] = 0;
      end else if (rv) begin
        mpc[k] = rt;
        if (k == 0 && rt[1:0] != 2'b00) mst[k] = 2;
      end else if (ready && !stall) begin
        if (pop && msz[k] > 0) begin
          mpc[k] = mras[k][msz[k]-1];
          if (push) mras[k][msz[k]-1] = pp;
          else msz[k]--;
        end else begin
          if (push) begin
            if (msz[k] == 4) begin
              for (int j = 0; j < 3; j++) mras[k][j] = mras[k][j+1];
              msz[k] = 3;
            end
            mras[k][msz[k]] = pp;
            msz[k]++;
          end
          mpc[k] = pp;
        end
      end
    end
    if (!rst) minit = 1;
  endtask
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    if (minit) begin
      chk("m4.pc", f4.pc, mpc[0]);
      chk("m4.pc_plus", f4.pc_plus, mpc[0] + 32'd4);
      chk("m4.fetch_valid", 32'(f4.fetch_valid), 32'(mst[0] == 1));
      chk("m4.misaligned", 32'(mf4), 32'(mst[0] == 2));
      chk("m4.ras_empty", 32'(re4), 32'(msz[0] == 0));
      chk("m1.pc", f1.pc, mpc[1]);
      chk("m1.pc_plus", f1.pc_plus, mpc[1] + 32'd1);
      chk("m1.fetch_valid", 32'(f1.fetch_valid), 32'(mst[1] == 1));
      chk("m1.misaligned", 32'(mf1), 32'(mst[1] == 2));
      chk("m1.ras_empty", 32'(re1), 32'(msz[1] == 0));
    end
  endtask
  task automatic go(logic r_v, logic [31:0] t, logic pu, logic po);
    rst = 1; ready = 1; stall = 0; tv = 0;
    rv = r_v; rt = t; push = pu; pop = po;
    cyc();
  endtask
  typedef struct {
    logic r, rdy, st, rv, tv, pu, po;
    logic [31:0] rt, tt, epc;
    logic efv, emf, ere;
  } vec_t;
  vec_t tbl [$];
  function automatic vec_t v(logic r, logic rdy, logic st, logic rvl, logic [31:0] rtg, logic tvl,
                             logic [31:0] ttg, logic pu, logic po, logic [31:0] epc,
                             logic efv, logic emf, logic ere);
    vec_t x;
    x.r = r; x.rdy = rdy; x.st = st; x.rv = rvl; x.rt = rtg; x.tv = tvl; x.tt = ttg;
    x.pu = pu; x.po = po; x.epc = epc; x.efv = efv; x.emf = emf; x.ere = ere;
    return x;
  endfunction
  initial begin
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h100, 1, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h104, 1, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h108, 1, 0, 1));
    tbl.push_back(v(1, 1, 0, 1, 32'h20, 0, 0, 0, 0, 32'h20, 1, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20, 1, 0, 1));
    tbl.push_back(v(1, 0, 1, 1, 32'h40, 0, 0, 0, 0, 32'h40, 1, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 1, 0, 32'h44, 1, 0, 0));
    tbl.push_back(v(1, 1, 0, 1, 32'h40, 1, 32'h80, 0, 0, 32'h80, 1, 0, 1));
    tbl.push_back(v(1, 1, 0, 1, 32'h102, 0, 0, 0, 0, 32'h102, 0, 1, 1));
    tbl.push_back(v(1, 1, 0, 1, 32'h40, 0, 0, 0, 0, 32'h102, 0, 1, 1));
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 32'h200, 0, 0, 32'h200, 1, 0, 1));
    tbl.push_back(v(1, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 1, 0, 32'h4, 1, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 1, 1, 32'h4, 1, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h8, 1, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 1, 32'hC, 1, 0, 1));
    foreach (tbl[i]) begin
      rst = tbl[i].r; ready = tbl[i].rdy; stall = tbl[i].st; rv = tbl[i].rv; rt = tbl[i].rt;
      tv = tbl[i].tv; tt = tbl[i].tt; push = tbl[i].pu; pop = tbl[i].po;
      cyc();
      chk($sformatf("vec%0d.pc", i), f4.pc, tbl[i].epc);
      chk($sformatf("vec%0d.fetch_valid", i), 32'(f4.fetch_valid), 32'(tbl[i].efv));
      chk($sformatf("vec%0d.misaligned", i), 32'(mf4), 32'(tbl[i].emf));
      chk($sformatf("vec%0d.ras_empty", i), 32'(re4), 32'(tbl[i].ere));
    end
    for (int i = 1; i <= 5; i++) begin
      go(1, 32'(10 * i), 0, 0);
      go(0, 0, 1, 0);
    end
    chk("ras.after_push", f1.pc, 32'd51);
    chk("ras.full", 32'(re1), 32'd0);
    go(0, 0, 0, 1);
    chk("ras.pop51", f1.pc, 32'd51);
    go(0, 0, 0, 1);
    chk("ras.pop41", f1.pc, 32'd41);
    go(0, 0, 0, 1);
    chk("ras.pop31", f1.pc, 32'd31);
    go(1, 32'd60, 0, 0);
    go(0, 0, 1, 1);
    chk("ras.pushpop", f1.pc, 32'd21);
    go(0, 0, 0, 1);
    chk("ras.pop61", f1.pc, 32'd61);
    chk("ras.empty", 32'(re1), 32'd1);
    go(0, 0, 0, 1);
    chk("ras.empty_pop_seq", f1.pc, 32'd62);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 99) != 0;
      ready = $urandom_range(0, 3) != 0;
      stall = $urandom_range(0, 4) == 0;
      rv = $urandom_range(0, 7) == 0;
      tv = $urandom_range(0, 15) == 0;
      rt = $urandom_range(0, 9) == 0 ? 32'hFFFF_FFF0 : $urandom;
      if ($urandom_range(0, 5) != 0) rt[1:0] = 2'b00;
      tt = $urandom & 32'hFFFF_FFFC;
      push = $urandom_range(0, 2) == 0;
      pop = $urandom_range(0, 2) == 0;
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
